// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, init-mode constants and init pattern for the data memory
package dmem_pkg;
  typedef enum logic {ST_INIT, ST_READY} state_t;
  localparam int INIT_ZERO = 0;
  localparam int INIT_RAMP = 1;
  // Ramp: lower half counts up from 0, upper half counts down from 0 (two's complement)
  function automatic logic [31:0] init_pattern(int idx, int data_w, int depth, int mode);
    logic [31:0] v;
    v = (mode == INIT_ZERO) ? 32'd0 : (idx < depth / 2) ? 32'(idx) : 32'(depth / 2 - idx);
    return (data_w >= 32) ? v : v & ((32'd1 << data_w) - 32'd1);
  endfunction
endpackage

// File: rtl/param_data_memory_if.sv
// param_data_memory_if: access bus between the CPU datapath and the data memory
interface param_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] ReadData;
  logic              read_valid;
  logic              ready;
  logic              addr_err;
  logic              led;
  modport master (
    output Address, WriteData, MemRead, MemWrite,
    input  ReadData, read_valid, ready, addr_err, led
  );
  modport slave (
    input  Address, WriteData, MemRead, MemWrite,
    output ReadData, read_valid, ready, addr_err, led
  );
endinterface

// File: rtl/dmem_init_seq.sv
// dmem_init_seq: post-reset init walk writing one pattern entry per cycle, then ready
module dmem_init_seq import dmem_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int INIT_MODE = INIT_RAMP,
  parameter int CW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_we,
  output logic [CW-1:0]     init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              ready
);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // Counter parks on the last index once READY is reached
  always_comb begin
    state_n = (state == ST_INIT && cnt == LAST) ? ST_READY : state;
    cnt_n   = (state == ST_INIT && cnt != LAST) ? cnt + 1'b1 : cnt;
  end
  always_comb begin
    init_we   = state == ST_INIT;
    init_addr = cnt;
    init_data = DATA_W'(init_pattern(int'(cnt), DATA_W, DEPTH, INIT_MODE));
    ready     = state == ST_READY;
  end
endmodule

// File: rtl/param_data_memory.sv
// param_data_memory: single-port data memory with sequenced init walk,
// registered read with valid strobe and out-of-range access flag
module param_data_memory import dmem_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 32,
  parameter int INIT_MODE = INIT_RAMP
) (
  input logic                clk,
  input logic                reset,
  param_data_memory_if.slave bus
);
  localparam int              CW    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              init_we, ready, in_range, we, rd_go;
  logic [CW-1:0]     init_addr, idx, wa;
  logic [DATA_W-1:0] init_data, wd, rd_q;
  logic              rv_q, err_q;
  dmem_init_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_MODE(INIT_MODE), .CW(CW)
  ) u_init (
    .clk(clk), .reset(reset), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .ready(ready)
  );
  // User accesses only count once the init walk has finished
  always_comb begin
    idx      = bus.Address[CW-1:0];
    in_range = {1'b0, bus.Address} < LIMIT;
    rd_go    = ready & bus.MemRead;
    we       = init_we | (ready & bus.MemWrite & in_range);
    wa       = init_we ? init_addr : idx;
    wd       = init_we ? init_data : bus.WriteData;
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  // Read samples the pre-write word, giving read-first on a same-address collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      rv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rv_q  <= rd_go;
      err_q <= ready & (bus.MemRead | bus.MemWrite) & ~in_range;
      if (rd_go) rd_q <= in_range ? mem[idx] : '0;
    end
  end
  assign bus.ReadData   = rd_q;
  assign bus.read_valid = rv_q;
  assign bus.addr_err   = err_q;
  assign bus.ready      = ready;
  assign bus.led        = ~ready;
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: two memory configurations checked every cycle against a
// behavioural model, plus directed literal checks of init values and corner cases
module tb_param_data_memory;
  logic clk = 0;
  logic reset = 1;
  bit   started = 0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;

  param_data_memory_if #(.DATA_W(8),  .ADDR_W(8)) i0 ();
  param_data_memory_if #(.DATA_W(16), .ADDR_W(8)) i1 ();

  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(32), .INIT_MODE(1))
    d0 (.clk(clk), .reset(reset), .bus(i0));
  param_data_memory #(.DATA_W(16), .ADDR_W(8), .DEPTH(64), .INIT_MODE(0))
    d1 (.clk(clk), .reset(reset), .bus(i1));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: posedges since reset decide readiness; memory is the pattern once ready
  int dep [2] = '{32, 64};
  int msk [2] = '{255, 65535};
  int mode[2] = '{1, 0};
  int mm  [2][64];
  int cyc [2];
  int e_rd[2];
  bit e_rv[2], e_err[2];
  bit mr, mw;
  int ma, md;

  function automatic int pat(int k, int c);
    if (mode[k] == 0) return 0;
    if (c < dep[k] / 2) return c;
    return (dep[k] / 2 - c) & msk[k];
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cyc[k] = 0; e_rd[k] = 0; e_rv[k] = 0; e_err[k] = 0;
      end else begin
        mr = (k == 0) ? i0.MemRead  : i1.MemRead;
        mw = (k == 0) ? i0.MemWrite : i1.MemWrite;
        ma = (k == 0) ? int'(i0.Address)   : int'(i1.Address);
        md = (k == 0) ? int'(i0.WriteData) : int'(i1.WriteData);
        if (cyc[k] < dep[k]) begin
          cyc[k]++;
          e_rv[k] = 0; e_err[k] = 0;
          if (cyc[k] == dep[k]) for (int c = 0; c < dep[k]; c++) mm[k][c] = pat(k, c);
        end else begin
          e_rv[k]  = mr;
          e_err[k] = (mr | mw) && ma >= dep[k];
          if (mr) e_rd[k] = (ma < dep[k]) ? mm[k][ma] : 0;
          if (mw && ma < dep[k]) mm[k][ma] = md;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rd0",    int'(i0.ReadData),   e_rd[0]);
      chk("rv0",    int'(i0.read_valid), int'(e_rv[0]));
      chk("err0",   int'(i0.addr_err),   int'(e_err[0]));
      chk("ready0", int'(i0.ready),      int'(cyc[0] == dep[0]));
      chk("led0",   int'(i0.led),        int'(cyc[0] != dep[0]));
      chk("rd1",    int'(i1.ReadData),   e_rd[1]);
      chk("rv1",    int'(i1.read_valid), int'(e_rv[1]));
      chk("err1",   int'(i1.addr_err),   int'(e_err[1]));
      chk("ready1", int'(i1.ready),      int'(cyc[1] == dep[1]));
      chk("led1",   int'(i1.led),        int'(cyc[1] != dep[1]));
    end
  end

  task automatic acc0(bit r, bit w, int a, int d);
    @(negedge clk);
    i0.MemRead = r; i0.MemWrite = w; i0.Address = 8'(a); i0.WriteData = 8'(d);
    @(negedge clk);
    i0.MemRead = 0; i0.MemWrite = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 reset = 1;
    @(negedge clk); #2 reset = 0;
  endtask

  task automatic wait_ready0();
    int n;
    n = 0;
    while (!i0.ready && n < 200) begin @(negedge clk); n++; end
    chk("ready0_timeout", int'(i0.ready), 1);
  endtask

  int pulses;

  initial begin
    i0.MemRead = 0; i0.MemWrite = 0; i0.Address = 0; i0.WriteData = 0;
    i1.MemRead = 0; i1.MemWrite = 0; i1.Address = 0; i1.WriteData = 0;
    repeat (3) @(negedge clk);
    started = 1;
    chk("reset_rd0", int'(i0.ReadData), 0);
    chk("reset_led0", int'(i0.led), 1);
    #2 reset = 0;
    // Ready after exactly DEPTH posedges
    repeat (31) @(posedge clk);
    #1 chk("ready0_at31", int'(i0.ready), 0);
    @(posedge clk);
    #1 chk("ready0_at32", int'(i0.ready), 1);
    chk("led0_at32", int'(i0.led), 0);
    repeat (31) @(posedge clk);
    #1 chk("ready1_at63", int'(i1.ready), 0);
    @(posedge clk);
    #1 chk("ready1_at64", int'(i1.ready), 1);
    // 64 back-to-back reads on the zero-init instance
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i > 0) pulses += int'(i1.read_valid);
      i1.MemRead = 1; i1.Address = 8'(i);
    end
    @(negedge clk);
    pulses += int'(i1.read_valid);
    chk("stream_last_rd", int'(i1.ReadData), 0);
    i1.MemRead = 0;
    @(negedge clk);
    chk("stream_pulses", pulses, 64);
    chk("stream_end_rv", int'(i1.read_valid), 0);
    // Ramp contents
    acc0(1, 0, 0, 0);  chk("rd_a0", int'(i0.ReadData), 0); chk("rv_a0", int'(i0.read_valid), 1);
    acc0(1, 0, 15, 0); chk("rd_a15", int'(i0.ReadData), 15);
    acc0(1, 0, 16, 0); chk("rd_a16", int'(i0.ReadData), 0);
    acc0(1, 0, 17, 0); chk("rd_a17", int'(i0.ReadData), 'hFF);
    acc0(1, 0, 31, 0); chk("rd_a31", int'(i0.ReadData), 'hF1);
    // Write then read, and read-first collision
    acc0(0, 1, 5, 'hA5);
    acc0(1, 0, 5, 0);     chk("rd_wr5", int'(i0.ReadData), 'hA5);
    acc0(1, 1, 5, 'h3C);  chk("rd_first", int'(i0.ReadData), 'hA5);
    acc0(1, 0, 5, 0);     chk("rd_after", int'(i0.ReadData), 'h3C);
    // Out of range
    acc0(1, 0, 40, 0);
    chk("oor_err", int'(i0.addr_err), 1); chk("oor_rv", int'(i0.read_valid), 1);
    chk("oor_rd", int'(i0.ReadData), 0);
    acc0(0, 1, 40, 'h99); chk("oor_wr_err", int'(i0.addr_err), 1);
    acc0(1, 0, 8, 0);     chk("alias8", int'(i0.ReadData), 8);
    // Reset mid-init restarts the full walk
    pulse_reset();
    repeat (10) @(posedge clk);
    @(negedge clk); #2 reset = 1;
    @(negedge clk); #2 reset = 0;
    repeat (31) @(posedge clk);
    #1 chk("restart_at31", int'(i0.ready), 0);
    @(posedge clk);
    #1 chk("restart_at32", int'(i0.ready), 1);
    acc0(0, 1, 3, 'h77);
    pulse_reset();
    acc0(0, 1, 2, 'hEE);
    chk("init_wr_err", int'(i0.addr_err), 0);
    wait_ready0();
    acc0(1, 0, 3, 0); chk("reinit3", int'(i0.ReadData), 3);
    acc0(1, 0, 2, 0); chk("init_wr_ign", int'(i0.ReadData), 2);
    // Randomized traffic on both instances, occasional reset
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(399) == 0) begin
        #2 reset = 1;
        @(negedge clk);
        #2 reset = 0;
      end
      i0.MemRead   = 1'($urandom_range(1));
      i0.MemWrite  = 1'($urandom_range(2) == 0);
      i0.Address   = 8'($urandom_range(47));
      i0.WriteData = 8'($urandom);
      i1.MemRead   = 1'($urandom_range(1));
      i1.MemWrite  = 1'($urandom_range(2) == 0);
      i1.Address   = 8'($urandom_range(79));
      i1.WriteData = 16'($urandom);
    end
    @(negedge clk);
    i0.MemRead = 0; i0.MemWrite = 0; i1.MemRead = 0; i1.MemWrite = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
